tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Time-division demultiplexer: the receiving end of a mux-based serial link.
//  A sender interleaves N_CH channels one slot per valid beat; slot 0 is marked by in_sync.
//  tdm_demux tracks slot position, collects one sample per channel into shadow registers,
//  then publishes the complete frame in parallel with a one-cycle out_valid strobe.
//  It sits between the serial link input and per-channel consumers.
// PARAMETERS
//  WIDTH  4  bits per channel sample (>=1)
//  N_CH   4  channels per frame (>=2)
//  SLOT_W 2  slot index width = clog2(N_CH); derived, not overridden
// PORTS
//  clk        in   1            rising-edge clock
//  reset_n    in   1            async active-low reset
//  in_valid   in   1            in_data/in_sync qualify this cycle
//  in_sync    in   1            beat carries slot 0 (only meaningful with in_valid)
//  in_data    in   WIDTH        sample for current slot
//  out_data   out  N_CH*WIDTH   last complete frame; ch k at [k*WIDTH +: WIDTH]
//  out_valid  out  1            1-cycle pulse: out_data updated this cycle
//  sync_err   out  1            1-cycle pulse: framing violation detected
//  locked     out  1            1 while in RUN state
// BEHAVIOUR
//  Reset (async assert, sync release): out_data=0, out_valid=0, sync_err=0, locked=0,
//   shadow regs=0, slot=0, state=HUNT. A reset mid-frame discards the partial frame.
//  FSM states: HUNT, RUN. All outputs registered.
//  HUNT: beats without in_sync are ignored. in_valid&in_sync -> shadow[0]<=in_data, slot<=1, ->RUN.
//  RUN, in_valid=0: hold everything (idle gaps of any length allowed).
//  RUN, in_valid=1, in_sync=0, 0<slot<N_CH-1: shadow[slot]<=in_data, slot<=slot+1.
//  RUN, in_valid=1, in_sync=0, slot==N_CH-1: out_data<={in_data,shadow[N_CH-2:0]},
//   out_valid=1 next cycle, slot<=0 (wrap). Latency: last beat edge -> out_valid 1 clk.
//  RUN, slot==0, in_valid=1, in_sync=1: normal frame start; shadow[0]<=in_data, slot<=1.
//  RUN, slot==0, in_valid=1, in_sync=0: missing sync -> sync_err=1, state->HUNT, beat dropped.
//  RUN, slot!=0, in_valid=1, in_sync=1: early sync -> sync_err=1; partial frame dropped
//   (out_valid stays 0); beat accepted as new slot 0: shadow[0]<=in_data, slot<=1, stay RUN.
//  out_data changes only on out_valid cycles; it holds between frames and through errors.
//  out_valid and sync_err are never high in the same cycle.
//  Back-to-back frames with no idle beats yield out_valid every N_CH cycles.
// STRUCTURE
//  Shared header tdm_defs.vh: state encodings ST_HUNT=1'b0, ST_RUN=1'b1; clog2 function.
//  Sub-module tdm_slot_ctr: slot counter with load-1, increment, wrap-to-0 and clear inputs,
//   plus a last-slot flag (slot==N_CH-1). Top holds FSM, shadow regs, output regs.
// TESTING (WIDTH=4, N_CH=4, 20 ns clock)
//  1 Reset then frame A,B,C,D (sync on A), contiguous -> 1 clk after D: out_valid=1,
//    out_data=16'hDCBA; locked=1 from the cycle after A.
//  2 Data 5,6,7 without sync in HUNT, then frame 1,2,3,4 -> exactly one out_valid,
//    out_data=16'h4321; no sync_err.
//  3 Frame 1,2 then sync beat 9, then A,B,C -> sync_err pulse after 9, no out_valid for
//    the partial frame; next out_valid with out_data=16'hCBA9.
//  4 Full frame then a slot-0 beat without sync -> sync_err=1, locked=0, out_data holds
//    previous frame value.
//  5 Frame beats separated by random idle gaps (in_valid=0, 0..5 cycles) -> same
//    out_data as contiguous case; two contiguous frames -> out_valid 4 cycles apart.
//  6 Assert reset_n=0 mid-frame (between clk edges) -> all outputs 0 immediately;
//    after release, a new full frame is required before out_valid.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state encodings and a
// constant-evaluable ceil(log2) helper used to size the slot index.
package tdm_demux_pkg;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tdm_demux_slot_ctr.sv
// Slot position counter for the TDM demux: clear, load-to-1, increment with
// wrap to 0 after the last slot, and a last-slot flag.
module tdm_demux_slot_ctr #(
  parameter int N_CH   = 4,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  assign last = (slot == SLOT_W'(N_CH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= last ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: tracks slot position on a serial TDM link,
// collects one sample per channel and publishes each complete frame in parallel.
//
//   state   | meaning
//   HUNT    | not framed; waiting for a valid beat carrying in_sync
//   RUN     | framed; collecting slots, publishing on the last slot
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N_CH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_sync,
  input  logic [WIDTH-1:0]      in_data,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  sync_err,
  output logic                  locked
);

  localparam int SLOT_W = clog2(N_CH);

  logic [0:0]            state_q;
  logic [WIDTH-1:0]      shadow_q [N_CH-1];
  logic [SLOT_W-1:0]     slot;
  logic                  slot_last;
  logic                  slot_zero;
  logic                  run;
  logic                  run_beat;
  logic                  start;
  logic                  err_early;
  logic                  err_missing;
  logic                  fin;
  logic                  mid;
  logic [N_CH*WIDTH-1:0] frame_next;

  assign run         = (state_q == ST_RUN);
  assign slot_zero   = (slot == '0);
  assign run_beat    = run & in_valid;
  assign start       = in_valid & in_sync;
  assign err_early   = run_beat & in_sync & ~slot_zero;
  assign err_missing = run_beat & ~in_sync & slot_zero;
  assign fin         = run_beat & ~in_sync & slot_last;
  assign mid         = run_beat & ~in_sync & ~slot_zero & ~slot_last;
  assign locked      = run;

  tdm_demux_slot_ctr #(
    .N_CH  (N_CH),
    .SLOT_W(SLOT_W)
  ) u_slot_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (err_missing),
    .load1  (start),
    .inc    (fin | mid),
    .slot   (slot),
    .last   (slot_last)
  );

  // The final slot goes straight to the output, never through a shadow register.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < N_CH - 1; k++) begin
      frame_next[k*WIDTH +: WIDTH] = shadow_q[k];
    end
    frame_next[(N_CH-1)*WIDTH +: WIDTH] = in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HUNT;
      out_data  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      for (int k = 0; k < N_CH - 1; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      out_valid <= fin;
      sync_err  <= err_early | err_missing;
      if (err_missing) begin
        state_q <= ST_HUNT;
      end else if (start) begin
        state_q <= ST_RUN;
      end
      if (fin) begin
        out_data <= frame_next;
      end
      if (start) begin
        shadow_q[0] <= in_data;
      end
      if (mid) begin
        for (int k = 1; k < N_CH - 1; k++) begin
          if (slot == SLOT_W'(k)) shadow_q[k] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed framing scenarios plus random
// beats, all compared against a queue-based behavioural model.
module tb_tdm_demux;

  localparam int WIDTH = 4;
  localparam int N_CH  = 4;

  logic                  clk;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_sync;
  logic [WIDTH-1:0]      in_data;
  logic [N_CH*WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  sync_err;
  logic                  locked;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int v_count  = 0;
  int e_count  = 0;
  int last_v   = -1;
  int prev_v   = -1;

  // behavioural model: framed flag plus the samples gathered so far this frame
  bit                    m_locked;
  logic [WIDTH-1:0]      m_q[$];
  logic [N_CH*WIDTH-1:0] m_data;
  bit                    m_valid;
  bit                    m_err;

  tdm_demux #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_data  (in_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .sync_err (sync_err),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_q.delete();
    m_data  = '0;
    m_valid = 0;
    m_err   = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [WIDTH-1:0] d);
    m_valid = 0;
    m_err   = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1;
        m_q.delete();
        m_q.push_back(d);
      end
    end else if (s) begin
      if (m_q.size() != 0) m_err = 1;
      m_q.delete();
      m_q.push_back(d);
    end else if (m_q.size() == 0) begin
      m_err    = 1;
      m_locked = 0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == N_CH) begin
        for (int k = 0; k < N_CH; k++) m_data[k*WIDTH +: WIDTH] = m_q[k];
        m_valid = 1;
        m_q.delete();
      end
    end
  endtask

  task automatic do_beat(input bit v, input bit s, input logic [WIDTH-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
    cyc++;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("sync_err",  32'(sync_err),  32'(m_err));
    check("locked",    32'(locked),    32'(m_locked));
    check("out_data",  32'(out_data),  32'(m_data));
    if (out_valid) begin
      v_count++;
      prev_v = last_v;
      last_v = cyc;
    end
    if (sync_err) e_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_beat(0, 0, 4'h0);
  endtask

  task automatic send_frame(input logic [N_CH*WIDTH-1:0] f, input int max_gap);
    for (int k = 0; k < N_CH; k++) begin
      do_beat(1, (k == 0), f[k*WIDTH +: WIDTH]);
      if (max_gap > 0 && k < N_CH - 1) idle(int'($urandom_range(max_gap, 0)));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    model_reset();
    #5;
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_sync_err",  32'(sync_err),  32'h0);
    check("rst_locked",    32'(locked),    32'h0);
    do_reset();

    // 1: contiguous frame A,B,C,D
    do_beat(1, 1, 4'hA);
    check("t1_locked_after_a", 32'(locked), 32'h1);
    do_beat(1, 0, 4'hB);
    do_beat(1, 0, 4'hC);
    do_beat(1, 0, 4'hD);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data",  32'(out_data),  32'hDCBA);
    idle(2);

    // 2: unsynced beats while hunting, then a frame
    do_reset();
    v_count = 0;
    e_count = 0;
    do_beat(1, 0, 4'h5);
    do_beat(1, 0, 4'h6);
    do_beat(1, 0, 4'h7);
    check("t2_hunt_locked", 32'(locked), 32'h0);
    send_frame(16'h4321, 0);
    idle(3);
    check("t2_valid_count", 32'(v_count), 32'h1);
    check("t2_err_count",   32'(e_count), 32'h0);
    check("t2_data",        32'(out_data), 32'h4321);

    // 3: early sync mid-frame
    v_count = 0;
    do_beat(1, 1, 4'h1);
    do_beat(1, 0, 4'h2);
    do_beat(1, 1, 4'h9);
    check("t3_early_err", 32'(sync_err), 32'h1);
    do_beat(1, 0, 4'hA);
    do_beat(1, 0, 4'hB);
    do_beat(1, 0, 4'hC);
    check("t3_data", 32'(out_data), 32'hCBA9);
    check("t3_valid_count", 32'(v_count), 32'h1);
    idle(1);

    // 4: missing sync on slot 0
    send_frame(16'h8E3F, 0);
    do_beat(1, 0, 4'h6);
    check("t4_err",    32'(sync_err), 32'h1);
    check("t4_locked", 32'(locked),   32'h0);
    check("t4_hold",   32'(out_data), 32'h8E3F);
    idle(2);

    // 5: random idle gaps, then two back-to-back frames
    send_frame(16'hDCBA, 5);
    check("t5_gap_data", 32'(out_data), 32'hDCBA);
    idle(1);
    send_frame(16'h1357, 0);
    send_frame(16'h2468, 0);
    check("t5_b2b_spacing", 32'(last_v - prev_v), 32'd4);
    check("t5_b2b_data", 32'(out_data), 32'h2468);

    // 6: async reset mid-frame
    do_beat(1, 1, 4'h3);
    do_beat(1, 0, 4'h4);
    #4;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_data",   32'(out_data),  32'h0);
    check("t6_rst_valid",  32'(out_valid), 32'h0);
    check("t6_rst_err",    32'(sync_err),  32'h0);
    check("t6_rst_locked", 32'(locked),    32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    v_count = 0;
    do_beat(1, 0, 4'h5);
    do_beat(1, 0, 4'h6);
    check("t6_no_valid", 32'(v_count), 32'h0);
    send_frame(16'h7A5C, 0);
    check("t6_new_frame", 32'(out_data), 32'h7A5C);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bit v;
      bit s;
      v = ($urandom_range(3, 0) != 0);
      s = ($urandom_range(4, 0) == 0);
      do_beat(v, s, 4'($urandom));
    end
    for (int i = 0; i < 10; i++) send_frame(16'($urandom), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
